// File: rtl/pk_link_pkg.sv
// pk_link_pkg -- shared constants and types for the pk_link panel link.
//   Command classes decoded from rx_byte[7:5], frame header base, TX FSM
//   state encoding and the rotary default/invalid values.
package pk_link_pkg;

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_FN   = 3'b001;
    localparam logic [2:0] CMD_GRP  = 3'b010;
    localparam logic [2:0] CMD_KEY  = 3'b011;
    localparam logic [2:0] CMD_RSV  = 3'b100;
    localparam logic [2:0] CMD_ROT  = 3'b101;
    localparam logic [2:0] CMD_STAT = 3'b110;
    localparam logic [2:0] CMD_CLR  = 3'b111;

    localparam logic [7:0] HDR_BASE       = 8'hC0;
    localparam logic [3:0] ROTARY_DEFAULT = 4'd1;
    localparam logic [3:0] ROTARY_INVALID = 4'hF;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_SEND    = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_e;

endpackage

// File: rtl/pk_link_tx.sv
// pk_link_tx -- status frame transmitter.
//   On a request in IDLE the status word is snapshotted and a frame is sent:
//   header (HDR_BASE | STATUS_BYTES-1) followed by the snapshot bytes, byte 0
//   (MSBs) first. Each byte waits for the UART to go idle, pulses tx_start,
//   then waits for busy to rise and fall again.
//   Handshake: o_tx_start is a one-cycle strobe with o_tx_byte valid in the
//   same cycle; i_tx_busy high means the UART owns the byte, and the next
//   byte is only offered once busy has been seen high and then low.
// Ports:
//   CLK_EXT, rst      clock, synchronous active-high reset
//   i_req             frame request (ignored unless IDLE)
//   i_status          status word, byte 0 in the MSBs
//   i_tx_busy         UART busy
//   o_tx_byte         byte to send (held between strobes)
//   o_tx_start        one-cycle send strobe
//   o_state           current FSM state (debug/observation)
module pk_link_tx
    import pk_link_pkg::*;
#(
    parameter int STATUS_BYTES = 4
) (
    input  logic                      CLK_EXT,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [8*STATUS_BYTES-1:0] i_status,
    input  logic                      i_tx_busy,
    output logic [7:0]                o_tx_byte,
    output logic                      o_tx_start,
    output tx_state_e                 o_state
);

    localparam int         SW        = 8 * STATUS_BYTES;
    localparam logic [7:0] HDR       = HDR_BASE | 8'(STATUS_BYTES - 1);
    // Byte count of a whole frame (header + payload).
    localparam logic [4:0] FRAME_LEN = 5'(STATUS_BYTES + 1);

    tx_state_e       r_state;
    tx_state_e       w_state_nxt;
    logic [4:0]      r_idx;        // bytes already strobed in this frame
    logic [SW-1:0]   r_snap;       // next payload byte always in the MSBs
    logic [7:0]      r_tx_byte;
    logic            r_tx_start;
    logic            w_fire;
    logic            w_load;
    logic [7:0]      w_byte;

    // State register
    always_ff @(posedge CLK_EXT) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE:    if (i_req)      w_state_nxt = TX_SEND;
            TX_SEND:    if (!i_tx_busy) w_state_nxt = TX_WAIT_HI;
            TX_WAIT_HI: if (i_tx_busy)  w_state_nxt = TX_WAIT_LO;
            TX_WAIT_LO: if (!i_tx_busy)
                            w_state_nxt = (r_idx == FRAME_LEN) ? TX_IDLE : TX_SEND;
            default:    w_state_nxt = TX_IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        w_fire = (r_state == TX_SEND) && !i_tx_busy;
        w_load = (r_state == TX_IDLE) && i_req;
        w_byte = (r_idx == 5'd0) ? HDR : r_snap[SW-1 -: 8];
    end

    always_ff @(posedge CLK_EXT) begin
        if (rst) begin
            r_idx      <= '0;
            r_snap     <= '0;
            r_tx_byte  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= w_fire;
            if (w_load) begin
                r_snap <= i_status;
                r_idx  <= '0;
            end else if (w_fire) begin
                r_tx_byte <= w_byte;
                r_idx     <= r_idx + 5'd1;
                // Payload bytes shift out; the header does not consume one.
                if (r_idx != 5'd0) r_snap <= r_snap << 8;
            end
        end
    end

    assign o_tx_byte  = r_tx_byte;
    assign o_tx_start = r_tx_start;
    assign o_state    = r_state;

endmodule

// File: rtl/pk_link.sv
// pk_link -- front-panel command link.
//   Decodes one-byte commands into data keys, function keys (with a shared
//   monostable hold for MONO_MASK keys) and a rotary index, and returns
//   status frames through pk_link_tx.
//   Optional build macro PK_LINK_AUTOSTAT_EN: adds AUTOSTAT_TICKS and a
//   free-running counter that requests a status frame every period (dropped
//   silently if a frame is already in flight).
// Ports:
//   CLK_EXT, rst          clock, synchronous active-high reset
//   rx_byte, rx_valid     command byte and its one-cycle strobe
//   status                panel status, byte 0 in the MSBs
//   tx_busy               UART busy
//   tx_byte, tx_start     byte to send and its one-cycle strobe
//   keys, fnkey, rotary   panel outputs
//   cmd_err               one-cycle strobe on an ignored/invalid command
module pk_link
    import pk_link_pkg::*;
#(
    parameter int              KEYS_W       = 16,
    parameter int              FN_N         = 12,
    parameter logic [FN_N-1:0] MONO_MASK    = 12'hFF8,
    parameter int              PULSE_TICKS  = 1000,
    parameter int              STATUS_BYTES = 4
`ifdef PK_LINK_AUTOSTAT_EN
    , parameter int            AUTOSTAT_TICKS = 50_000
`endif
) (
    input  logic                      CLK_EXT,
    input  logic                      rst,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_valid,
    input  logic [8*STATUS_BYTES-1:0] status,
    input  logic                      tx_busy,
    output logic [7:0]                tx_byte,
    output logic                      tx_start,
    output logic [KEYS_W-1:0]         keys,
    output logic [FN_N-1:0]           fnkey,
    output logic [3:0]                rotary,
    output logic                      cmd_err
);

    localparam int              CNT_W      = $clog2(PULSE_TICKS + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_TICKS);

    logic [KEYS_W-1:0] r_keys,   w_keys_nxt;
    logic [FN_N-1:0]   r_fnkey,  w_fnkey_nxt;
    logic [4:0]        r_grp,    w_grp_nxt;
    logic [3:0]        r_rot,    w_rot_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;   // 0 = idle, else cycles left
    logic              r_cmd_err, w_err;
    logic              w_stat_req;
    logic              w_tx_req;
    logic              w_tx_idle;
    tx_state_e         w_tx_state;

    // Key group placement: group g occupies bits [5g+4:5g]; bits past
    // KEYS_W-1 simply fall off when the shifted data is truncated.
    logic [7:0]        w_base;
    logic [36:0]       w_kdata, w_kmask;
    logic              w_key_ok;
    logic [3:0]        w_fn_idx;
    logic              w_fn_ok;

    assign w_base   = {3'b0, r_grp} * 8'd5;
    assign w_kdata  = {32'b0, rx_byte[4:0]} << w_base;
    assign w_kmask  = {32'b0, 5'h1F} << w_base;
    assign w_key_ok = ({24'b0, w_base} < 32'(KEYS_W));
    assign w_fn_idx = rx_byte[4:1];
    assign w_fn_ok  = ({28'b0, w_fn_idx} < 32'(FN_N));
    assign w_tx_idle = (w_tx_state == TX_IDLE);

    always_comb begin
        w_keys_nxt  = r_keys;
        w_fnkey_nxt = r_fnkey;
        w_grp_nxt   = r_grp;
        w_rot_nxt   = r_rot;
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
        w_stat_req  = 1'b0;

        // Monostable timer runs first so a set in the expiry cycle overrides it.
        if (r_cnt == CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_fnkey_nxt = r_fnkey & ~MONO_MASK;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end

        if (rx_valid) begin
            case (rx_byte[7:5])
                CMD_NOP: ;
                CMD_FN: begin
                    if (w_fn_ok) begin
                        for (int i = 0; i < FN_N; i++) begin
                            if (w_fn_idx == 4'(i)) begin
                                w_fnkey_nxt[i] = rx_byte[0];
                                if (rx_byte[0] && MONO_MASK[i]) w_cnt_nxt = PULSE_LOAD;
                            end
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                CMD_GRP: w_grp_nxt = rx_byte[4:0];
                CMD_KEY: begin
                    w_grp_nxt = r_grp + 5'd1;
                    if (w_key_ok)
                        w_keys_nxt = (r_keys & ~w_kmask[KEYS_W-1:0]) | w_kdata[KEYS_W-1:0];
                    else
                        w_err = 1'b1;
                end
                CMD_RSV: w_err = 1'b1;
                CMD_ROT: begin
                    if (rx_byte[3:0] == ROTARY_INVALID) w_err = 1'b1;
                    else                                w_rot_nxt = rx_byte[3:0];
                end
                CMD_STAT: begin
                    if (w_tx_idle) w_stat_req = 1'b1;
                    else           w_err      = 1'b1;
                end
                CMD_CLR: begin
                    w_keys_nxt  = '0;
                    w_fnkey_nxt = '0;
                    w_grp_nxt   = '0;
                    w_rot_nxt   = ROTARY_DEFAULT;
                    w_cnt_nxt   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_EXT) begin
        if (rst) begin
            r_keys    <= '0;
            r_fnkey   <= '0;
            r_grp     <= '0;
            r_rot     <= ROTARY_DEFAULT;
            r_cnt     <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_keys    <= w_keys_nxt;
            r_fnkey   <= w_fnkey_nxt;
            r_grp     <= w_grp_nxt;
            r_rot     <= w_rot_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cmd_err <= w_err;
        end
    end

`ifdef PK_LINK_AUTOSTAT_EN
    localparam int               AUTO_W    = $clog2(AUTOSTAT_TICKS + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTOSTAT_TICKS - 1);

    logic [AUTO_W-1:0] r_auto_cnt;
    logic              w_auto_req;

    assign w_auto_req = (r_auto_cnt == AUTO_LAST);

    always_ff @(posedge CLK_EXT) begin
        if (rst || w_auto_req) r_auto_cnt <= '0;
        else                   r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
    end

    // Periodic requests are only issued when the transmitter can take them.
    assign w_tx_req = w_stat_req | (w_auto_req & w_tx_idle);
`else
    assign w_tx_req = w_stat_req;
`endif

    pk_link_tx #(
        .STATUS_BYTES (STATUS_BYTES)
    ) u_tx (
        .CLK_EXT    (CLK_EXT),
        .rst        (rst),
        .i_req      (w_tx_req),
        .i_status   (status),
        .i_tx_busy  (tx_busy),
        .o_tx_byte  (tx_byte),
        .o_tx_start (tx_start),
        .o_state    (w_tx_state)
    );

    assign keys    = r_keys;
    assign fnkey   = r_fnkey;
    assign rotary  = r_rot;
    assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_pk_link.sv
// tb_pk_link -- directed bench for pk_link (default build).
module tb_pk_link;

    localparam int P = 20;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] status = 32'h0;
    logic        tx_busy;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic [15:0] keys;
    logic [11:0] fnkey;
    logic [3:0]  rotary;
    logic        cmd_err;

    pk_link #(.PULSE_TICKS(P)) dut (
        .CLK_EXT  (clk),
        .rst      (rst),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .status   (status),
        .tx_busy  (tx_busy),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .keys     (keys),
        .fnkey    (fnkey),
        .rotary   (rotary),
        .cmd_err  (cmd_err)
    );

    // ---------------- UART model ----------------
    int         busy_cnt  = 0;
    int         start_cnt = 0;
    int         b2b       = 0;
    logic       prev_start = 1'b0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start) begin
            obs_q.push_back(tx_byte);
            start_cnt++;
            if (prev_start) b2b++;
            busy_cnt <= 10;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        prev_start <= tx_start;
    end

    // ---------------- scoreboard helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; command is sampled at the next posedge and the
    // task returns at the following negedge where its effect is visible.
    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic measure_high(input int bit_i, output int n);
        n = 0;
        while (fnkey[bit_i] && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_starts(input int target);
        for (int i = 0; i < 400; i++) begin
            if (start_cnt >= target) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int base;
        logic [7:0] got;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_keys",     32'(keys),     32'h0);
        check("rst_fnkey",    32'(fnkey),    32'h0);
        check("rst_rotary",   32'(rotary),   32'h1);
        check("rst_cmd_err",  32'(cmd_err),  32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_byte",  32'(tx_byte),  32'h0);

        // Function keys
        send(8'h23);                          // fnkey[1]=1, not monostable
        check("fn1_set", 32'(fnkey), 32'h002);
        send(8'h3F);                          // index 15 out of range
        check("fn_bad_err", 32'(cmd_err), 32'h1);
        check("fn_bad_keep", 32'(fnkey), 32'h002);
        @(negedge clk);
        check("fn_err_one_cycle", 32'(cmd_err), 32'h0);
        send(8'h29);                          // fnkey[4]=1 (mono)
        check("fn4_set", 32'(fnkey), 32'h012);
        send(8'h28);                          // fnkey[4]=0 immediately
        check("fn4_clr", 32'(fnkey), 32'h002);

        // Monostable hold
        send(8'h27);
        measure_high(3, n);
        check("mono_width", 32'(n), 32'(P));
        check("mono_nonmono_kept", 32'(fnkey), 32'h002);
        send(8'h27);
        repeat (P - 1) @(negedge clk);
        send(8'h27);                          // lands on the expiry edge
        check("mono_expiry_set", 32'(fnkey[3]), 32'h1);
        measure_high(3, n);
        check("mono_reload_width", 32'(n), 32'(P));

        // Data key groups
        send(8'h40);
        send(8'h75);
        check("key_g0_err", 32'(cmd_err), 32'h0);
        send(8'h6A);
        send(8'h7F);
        send(8'h61);
        check("keys_fd55", 32'(keys), 32'hFD55);
        check("key_g3_err", 32'(cmd_err), 32'h0);
        send(8'h61);                          // g=4 -> beyond width
        check("key_g4_err", 32'(cmd_err), 32'h1);
        check("key_g4_keep", 32'(keys), 32'hFD55);
        send(8'h80);                          // reserved
        check("rsv_err", 32'(cmd_err), 32'h1);

        // Rotary
        send(8'hAF);
        check("rot15_err", 32'(cmd_err), 32'h1);
        check("rot15_keep", 32'(rotary), 32'h1);
        send(8'hA9);
        check("rot9", 32'(rotary), 32'h9);
        check("rot9_err", 32'(cmd_err), 32'h0);

        // Panel clear, then group pointer restarts at 0
        send(8'hE0);
        check("clr_keys",   32'(keys),   32'h0);
        check("clr_fnkey",  32'(fnkey),  32'h0);
        check("clr_rotary", 32'(rotary), 32'h1);
        send(8'h75);
        check("clr_grp0", 32'(keys), 32'h0015);

        // Status frame
        status = 32'h12345678;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        send(8'hC0);
        status = 32'hDEADBEEF;                // snapshot must ignore this
        repeat (20) @(negedge clk);
        send(8'hC0);
        check("stat_busy_err", 32'(cmd_err), 32'h1);
        wait_starts(5);
        repeat (30) @(negedge clk);
        check("frame_starts", 32'(start_cnt), 32'd5);
        for (int i = 0; i < 5; i++) begin
            got = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            check($sformatf("frame_byte%0d", i), 32'(got), 32'(exp_q.pop_front()));
        end
        check("no_b2b_start", 32'(b2b), 32'd0);

        // Reset in mid-frame
        send(8'hA5);
        send(8'h23);
        check("pre_rst_rot", 32'(rotary), 32'h5);
        base = start_cnt;
        send(8'hC0);
        wait_starts(base + 2);
        check("midframe_starts", 32'(start_cnt), 32'(base + 2));
        rst = 1'b1;
        @(negedge clk);
        check("mrst_tx_start", 32'(tx_start), 32'h0);
        check("mrst_tx_byte",  32'(tx_byte),  32'h0);
        check("mrst_keys",     32'(keys),     32'h0);
        check("mrst_fnkey",    32'(fnkey),    32'h0);
        check("mrst_rotary",   32'(rotary),   32'h1);
        check("mrst_cmd_err",  32'(cmd_err),  32'h0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("mrst_no_more_start", 32'(start_cnt), 32'(base + 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
